// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame format constants, timer sizing
// and the memory-mapped register addresses used by the CPU-side UART.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, START, DATA, STOP, GAP, FIN
    } uart_state_e;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [31:0] UART_DATA_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] UART_CTRL_ADDR = 32'hFFFF_0008;

    function automatic int bit_timer_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake; a queued byte is taken on the
// last stop/gap clock so back-to-back bytes leave no idle cycle on the line.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       clr,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       byte_done,
    output logic       TX
);
    localparam int TW = bit_timer_w((BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES);
    localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

    uart_state_e   st, st_n;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end, gap_end;

    always_comb begin
        bit_end   = (timer == BIT_LAST);
        gap_end   = (timer == GAP_LAST);
        byte_done = ((st == STOP) && bit_end && (GAP_CYCLES == 0)) || ((st == GAP) && gap_end);
        ready     = (st == IDLE) || byte_done;
        st_n      = st;
        case (st)
            IDLE:    if (valid) st_n = START;
            START:   if (bit_end) st_n = DATA;
            DATA:    if (bit_end && (bit_idx == 3'(DATA_BITS - 1))) st_n = STOP;
            STOP:    if (bit_end) st_n = (GAP_CYCLES == 0) ? (valid ? START : IDLE) : GAP;
            GAP:     if (gap_end) st_n = valid ? START : IDLE;
            default: st_n = IDLE;
        endcase
        if (clr) st_n = IDLE;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            st      <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            TX      <= 1'b1;
        end else begin
            st <= st_n;
            if (clr) begin
                timer <= '0;
                TX    <= 1'b1;
            end else if (ready && valid) begin
                timer   <= '0;
                bit_idx <= '0;
                TX      <= 1'b0;
            end else begin
                case (st)
                    START: begin
                        timer <= bit_end ? '0 : timer + 1'b1;
                        if (bit_end) TX <= shreg[0];
                    end
                    DATA: begin
                        timer <= bit_end ? '0 : timer + 1'b1;
                        if (bit_end) begin
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
                                TX <= 1'b1;
                            end else begin
                                TX      <= shreg[bit_idx + 3'd1];
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    STOP:    timer <= bit_end ? '0 : timer + 1'b1;
                    GAP:     timer <= gap_end ? '0 : timer + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (ready && valid && !clr) shreg <= data;
    end

endmodule

// File: rtl/uart_prog_sender.sv
// Streams a block of 32-bit words from a synchronous-read memory onto a UART line,
// four 8N1 bytes per word, least-significant byte first.
module uart_prog_sender
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ   = 50_000_000,
    parameter int          BAUD_RATE  = 9600,
    parameter int          GAP_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_words,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd,
    output logic        TX,
    output logic        busy,
    output logic        done,
    output logic [15:0] words_sent
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;

    uart_state_e state, state_n;
    logic [15:0] count;
    logic [2:0]  idx;
    logic [31:0] word;
    logic [7:0]  byte_data;
    logic        byte_valid, tx_ready, byte_done, hs, word_end, last_word, kill;

    uart_tx_byte #(
        .BIT_CYCLES(BIT_CYCLES),
        .GAP_CYCLES(GAP_CYCLES)
    ) u_tx (
        .CLK      (CLK),
        .reset    (reset),
        .clr      (kill),
        .valid    (byte_valid && !kill),
        .data     (byte_data),
        .ready    (tx_ready),
        .byte_done(byte_done),
        .TX       (TX)
    );

    // Byte 0 goes straight from the memory port, so the word register is only needed for bytes 1-3.
    always_comb begin
        kill       = abort && (state != IDLE);
        byte_valid = (state == START) && (idx < 3'(BYTES_PER_WORD));
        byte_data  = (idx == 3'd0) ? mem_rd[7:0] : word[8*idx[1:0] +: 8];
        hs         = byte_valid && tx_ready && !kill;
        word_end   = (state == START) && (idx == 3'(BYTES_PER_WORD)) && byte_done;
        last_word  = ((words_sent + 16'd1) == count);
        state_n    = state;
        case (state)
            IDLE:    if (start && (num_words != 16'd0)) state_n = FETCH;
            FETCH:   state_n = LATCH;
            LATCH:   state_n = START;
            START:   if (word_end) state_n = last_word ? FIN : LATCH;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) state_n = IDLE;
    end

    // The read strobe is issued on entry to LATCH; between words FETCH is skipped.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            idx        <= '0;
            words_sent <= '0;
            mem_addr   <= BASE_ADDR;
            mem_re     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state  <= state_n;
            mem_re <= (state_n == LATCH);
            done   <= 1'b0;
            if (kill) begin
                busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        if (num_words != 16'd0) begin
                            count      <= num_words;
                            words_sent <= '0;
                            mem_addr   <= BASE_ADDR;
                            idx        <= '0;
                            busy       <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    START: begin
                        if (hs) idx <= idx + 3'd1;
                        if (word_end) begin
                            words_sent <= words_sent + 16'd1;
                            mem_addr   <= mem_addr + 32'd4;
                            idx        <= '0;
                        end
                    end
                    FIN: begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (hs && (idx == 3'd0)) word <= mem_rd;
    end

endmodule

// File: doc/uart_prog_sender.md
Name: uart_prog_sender

Overview:
Host-side UART program streamer: reads a block of 32-bit words from a local synchronous-read memory and transmits each word as four 8N1 bytes, least-significant byte first. The byte stream matches the format the CPU-side UART programming receiver expects, so each group of four bytes becomes one instruction-memory word write at the target. Used on the loader/bench side and in the SoC self-test path to drive a target's RX line.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD_RATE, 9600, line rate in bit/s; BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer division); every line bit lasts exactly BIT_CYCLES clocks.
GAP_CYCLES, 0, extra idle-high clocks inserted after every stop bit.
BASE_ADDR, 32'h00000000, first memory byte address read.

Ports:
CLK  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a transfer; sampled only in IDLE
abort  input  1  synchronous cancel of an active transfer
num_words  input  16  number of words to send; sampled together with start
mem_re  output  1  memory read strobe
mem_addr  output  32  memory byte address (word-aligned)
mem_rd  input  32  read data, valid the cycle after mem_re
TX  output  1  serial line, idle high
busy  output  1  high from the cycle after start is accepted until return to IDLE
done  output  1  one-cycle pulse on normal completion
words_sent  output  16  count of fully transmitted words in the current or last transfer

Behaviour:
- Reset (async): TX=1, busy=0, done=0, mem_re=0, mem_addr=BASE_ADDR, words_sent=0, state IDLE. Reset mid-frame forces TX high immediately.
- All outputs are registered.
- States: IDLE, FETCH, LATCH, START, DATA, STOP, GAP, FIN.
- IDLE: TX=1. On start=1 with num_words!=0: latch num_words, clear words_sent, set mem_addr=BASE_ADDR, busy=1, go to FETCH. On start=1 with num_words==0: pulse done in the next cycle, busy stays 0, TX is unchanged.
- FETCH: mem_re=1 for exactly one cycle, then LATCH.
- LATCH: capture mem_rd into the 32-bit shift word, byte index=0, then START.
- Line timing: TX goes low on the 3rd rising edge after the edge that accepted start.
- START: TX=0 for BIT_CYCLES clocks.
- DATA: 8 bits, LSB first, each held BIT_CYCLES clocks.
- STOP: TX=1 for BIT_CYCLES clocks, then GAP (skipped if GAP_CYCLES=0).
- GAP: TX=1 for GAP_CYCLES clocks.
- After a stop bit (and gap), if byte index<3: byte index+1, next byte = word[8*idx+:8], go to START.
- After the 4th byte: words_sent+1 and mem_addr+4. If words_sent (new value) == latched count, go to FIN; otherwise go to FETCH.
- One word frame = 4*(10*BIT_CYCLES+GAP_CYCLES) clocks, plus 2 fetch/latch clocks between words.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- start while busy: ignored, no effect on the count or address.
- abort=1 in any non-IDLE state: next edge goes to IDLE with TX=1 and busy=0. done is not pulsed; words_sent holds. A truncated byte is allowed.
- abort and start together in IDLE: start wins and abort is ignored.
- Counter widths: the bit timer is clog2(BIT_CYCLES+1) bits, or 32 bits when simple; mem_addr wraps modulo 2^32.

Decomposition:
- Shared package uart_pkg:
  - state enum;
  - bit-timer width function;
  - frame-format constants (DATA_BITS=8, BYTES_PER_WORD=4);
  - memory-mapped UART addresses shared with the CPU-side UART.
- One sub-module, uart_tx_byte: an 8N1 byte serializer with valid/ready handshake, BIT_CYCLES and GAP_CYCLES parameters, and TX output.
- The top level keeps the fetch, word sequencing, count and abort logic.

Test Plan:
- CLK_FREQ=16, BAUD_RATE=1 (BIT_CYCLES=16); mem[0]=0x12345678; start with num_words=1 -> TX falls 3 edges after start, bytes on line 0x78,0x56,0x34,0x12. Each byte reads start=0, LSB-first data, stop=1, with 160 clocks per byte. Then done pulses once, words_sent=1, busy falls.
- num_words=3; mem = 0xDEADBEEF, 0x00000013, 0xFFFFFFFF -> 12 bytes EF BE AD DE 13 00 00 00 FF FF FF FF. mem_addr sequence 0, 4, 8 with exactly 3 mem_re pulses; words_sent=3.
- Loopback: connect TX to the CPU-side UART RX in prog mode, send 2 words -> the receiver issues imem writes (addr 0, 0x12345678) and (addr 4, 0xDEADBEEF).
- GAP_CYCLES=5 -> 5 idle-high clocks between every stop bit and the next start bit; word frame = 660 clocks.
- abort asserted mid-DATA of byte 2 -> TX=1 next cycle, busy=0, no done pulse, words_sent=0. A new start then restarts at BASE_ADDR.
- start with num_words=0 -> done pulses the next cycle, TX stays 1, no mem_re. A start pulse during an active transfer is ignored; async reset mid-bit forces TX=1 and busy=0 immediately.
